// File: rtl/coef_seq.sv
// Address sequencer/unpacker between coef_prom and the DDS core: fetches COUNT
// words from a base address, splits each into FTW/phase and presents it on valid/ready.
module coef_seq #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 48,
  parameter int FTW_W   = 32,
  parameter int PH_W    = 16,
  parameter int ROM_LAT = 2
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_ad_i,
  input  logic [ADDR_W:0]   count_i,
  output logic [ADDR_W-1:0] rom_ad_o,
  output logic              rom_ce_o,
  output logic              rom_oce_o,
  input  logic [DATA_W-1:0] rom_dout_i,
  output logic [FTW_W-1:0]  coef_ftw_o,
  output logic [PH_W-1:0]   coef_phase_o,
  output logic              coef_valid_o,
  input  logic              coef_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int WAIT_W = $clog2(ROM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_PRESENT
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [ADDR_W:0]     remain_q, remain_d;
  logic [ADDR_W-1:0]   ad_q, ad_d;
  logic                ce_q, ce_d;
  logic [FTW_W-1:0]    ftw_q, ftw_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // NOTE: every variable gets a hold/default value first so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    remain_d = remain_q;
    ad_d     = ad_q;
    ce_d     = ce_q;
    ftw_d    = ftw_q;
    ph_d     = ph_q;
    valid_d  = valid_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && (count_i != '0)) begin
          remain_d = count_i;
          ad_d     = base_ad_i;
          ce_d     = 1'b1;
          wait_d   = WAIT_W'(ROM_LAT);
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        // Counter hits zero once the ROM pipeline has delivered the addressed word.
        if (wait_q == '0) begin
          ftw_d   = rom_dout_i[DATA_W-1 -: FTW_W];
          ph_d    = rom_dout_i[PH_W-1:0];
          valid_d = 1'b1;
          state_d = S_PRESENT;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end

      S_PRESENT: begin
        if (coef_ready_i) begin
          valid_d = 1'b0;
          if (remain_q > (ADDR_W+1)'(1)) begin
            remain_d = remain_q - 1'b1;
            ad_d     = ad_q + 1'b1;
            wait_d   = WAIT_W'(ROM_LAT);
            state_d  = S_WAIT;
          end else begin
            remain_d = '0;
            ce_d     = 1'b0;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        ce_d    = 1'b0;
      end
    endcase
  end

  // Busy is registered from the next state so it tracks the state register exactly.
  assign busy_d = (state_d != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      remain_q <= '0;
      ad_q     <= '0;
      ce_q     <= 1'b0;
      ftw_q    <= '0;
      ph_q     <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      remain_q <= remain_d;
      ad_q     <= ad_d;
      ce_q     <= ce_d;
      ftw_q    <= ftw_d;
      ph_q     <= ph_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign rom_ad_o     = ad_q;
  assign rom_ce_o     = ce_q;
  assign rom_oce_o    = ce_q;
  assign coef_ftw_o   = ftw_q;
  assign coef_phase_o = ph_q;
  assign coef_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_coef_seq.sv
// Self-checking bench for coef_seq with a 2-clock coef_prom model and a
// scoreboard of expected {address, FTW, phase} per transfer.
module tb_coef_seq;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 48;
  localparam int FTW_W   = 32;
  localparam int PH_W    = 16;
  localparam int ROM_LAT = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] ad;
    logic [FTW_W-1:0]  ftw;
    logic [PH_W-1:0]   ph;
  } exp_t;

  logic              fg_clk = 1'b0;
  logic              rst_n  = 1'b0;
  logic              start  = 1'b0;
  logic [ADDR_W-1:0] base_ad = '0;
  logic [ADDR_W:0]   count   = '0;
  logic [ADDR_W-1:0] rom_ad;
  logic              rom_ce, rom_oce;
  logic [DATA_W-1:0] rom_s1, rom_dout;
  logic [FTW_W-1:0]  coef_ftw;
  logic [PH_W-1:0]   coef_phase;
  logic              coef_valid;
  logic              coef_ready = 1'b0;
  logic              busy, done;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   xfer_cnt = 0;
  int   done_cnt = 0;

  always #5 fg_clk = ~fg_clk;

  coef_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .FTW_W  (FTW_W),
    .PH_W   (PH_W),
    .ROM_LAT(ROM_LAT)
  ) dut (
    .Fg_CLK      (fg_clk),
    .RESETn      (rst_n),
    .start_i     (start),
    .base_ad_i   (base_ad),
    .count_i     (count),
    .rom_ad_o    (rom_ad),
    .rom_ce_o    (rom_ce),
    .rom_oce_o   (rom_oce),
    .rom_dout_i  (rom_dout),
    .coef_ftw_o  (coef_ftw),
    .coef_phase_o(coef_phase),
    .coef_valid_o(coef_valid),
    .coef_ready_i(coef_ready),
    .busy_o      (busy),
    .done_o      (done)
  );

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return {32'h1000_0000 + 32'(a), 16'hA000 + 16'(a)};
  endfunction

  // coef_prom model: address register stage then output register gated by oce.
  always @(posedge fg_clk) begin
    if (rom_ce)  rom_s1   <= rom_word(rom_ad);
    if (rom_oce) rom_dout <= rom_s1;
  end

  // Advance one clock; on the way, score any handshake seen at the negedge.
  task automatic step();
    exp_t e;
    @(negedge fg_clk);
    if (rst_n) begin
      if (coef_valid && coef_ready) begin
        xfer_cnt++;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL xfer_unexpected: got ad=%0h ftw=%h ph=%h, required no transfer",
                   rom_ad, coef_ftw, coef_phase);
        end else begin
          e = sb.pop_front();
          if ({rom_ad, coef_ftw, coef_phase} !== e) begin
            n_err++;
            $display("FAIL xfer_data: got ad=%0h ftw=%h ph=%h, required ad=%0h ftw=%h ph=%h",
                     rom_ad, coef_ftw, coef_phase, e.ad, e.ftw, e.ph);
          end
        end
      end
      if (done) done_cnt++;
    end
    @(posedge fg_clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c, input bit push);
    logic [ADDR_W-1:0] a;
    start   = 1'b1;
    base_ad = b;
    count   = c;
    step();
    start   = 1'b0;
    if (push) begin
      a = b;
      for (int i = 0; i < int'(c); i++) begin
        sb.push_back({a, rom_word(a)});
        a = a + 1'b1;
      end
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!coef_valid && cyc < 50) begin
      step();
      cyc++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    repeat (2) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (10) @(posedge fg_clk);
    #1;
    n_vec++;
    if ({rom_ad, rom_ce, rom_oce, coef_ftw, coef_phase, coef_valid, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ad=%0h ce=%b oce=%b ftw=%h ph=%h v=%b busy=%b done=%b, required all 0",
               rom_ad, rom_ce, rom_oce, coef_ftw, coef_phase, coef_valid, busy, done);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int cyc;
    coef_ready = 1'b1;
    do_start(4'd3, 5'd1, 1'b1);
    wait_valid(cyc);
    n_vec++;
    if (cyc !== 3) begin
      n_err++;
      $display("FAIL single_latency: got %0d clocks, required 3", cyc);
    end
    n_vec++;
    if ({coef_ftw, coef_phase} !== {32'h1000_0003, 16'hA003}) begin
      n_err++;
      $display("FAIL single_data: got ftw=%h ph=%h, required 10000003/a003", coef_ftw, coef_phase);
    end
    step();
    n_vec++;
    if ({done, busy, coef_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL single_done: got done=%b busy=%b valid=%b, required 1/0/0", done, busy, coef_valid);
    end
    step();
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL single_done_width: got done=%b one clock later, required 0", done);
    end
  endtask

  task automatic test_backpressure();
    int cyc, bad, x0, d0;
    logic [FTW_W-1:0] f0;
    logic [PH_W-1:0]  p0;
    x0 = xfer_cnt;
    d0 = done_cnt;
    coef_ready = 1'b0;
    do_start(4'd0, 5'd4, 1'b1);
    for (int w = 0; w < 4; w++) begin
      wait_valid(cyc);
      n_vec++;
      if (cyc !== 3) begin
        n_err++;
        $display("FAIL bp_latency word %0d: got %0d clocks, required 3", w, cyc);
      end
      f0  = coef_ftw;
      p0  = coef_phase;
      bad = 0;
      repeat (20) begin
        step();
        if (!coef_valid || coef_ftw !== f0 || coef_phase !== p0) bad++;
      end
      n_vec++;
      if (bad !== 0) begin
        n_err++;
        $display("FAIL bp_stable word %0d: got %0d unstable clocks, required 0", w, bad);
      end
      coef_ready = 1'b1;
      step();
      coef_ready = 1'b0;
    end
    repeat (3) step();
    n_vec++;
    if ((xfer_cnt - x0) !== 4 || (done_cnt - d0) !== 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_counts: got xfers=%0d dones=%0d busy=%b, required 4/1/0",
               xfer_cnt - x0, done_cnt - d0, busy);
    end
  endtask

  task automatic test_wrap();
    int x0, d0;
    x0 = xfer_cnt;
    d0 = done_cnt;
    coef_ready = 1'b1;
    do_start(4'd14, 5'd4, 1'b1);
    wait_idle();
    n_vec++;
    if ((xfer_cnt - x0) !== 4 || (done_cnt - d0) !== 1 || sb.size() !== 0) begin
      n_err++;
      $display("FAIL wrap_counts: got xfers=%0d dones=%0d pending=%0d, required 4/1/0",
               xfer_cnt - x0, done_cnt - d0, sb.size());
    end
  endtask

  task automatic test_ignored();
    int bad, x0, d0;
    coef_ready = 1'b1;
    d0  = done_cnt;
    bad = 0;
    do_start(4'd7, 5'd0, 1'b0);
    repeat (10) begin
      if (busy || done || coef_valid) bad++;
      step();
    end
    n_vec++;
    if (bad !== 0 || done_cnt !== d0) begin
      n_err++;
      $display("FAIL ign_count0: got %0d active clocks, %0d dones, required 0/0", bad, done_cnt - d0);
    end
    x0 = xfer_cnt;
    d0 = done_cnt;
    do_start(4'd2, 5'd3, 1'b1);
    repeat (3) step();
    do_start(4'd9, 5'd5, 1'b0);
    wait_idle();
    n_vec++;
    if ((xfer_cnt - x0) !== 3 || (done_cnt - d0) !== 1 || sb.size() !== 0) begin
      n_err++;
      $display("FAIL ign_midstart: got xfers=%0d dones=%0d pending=%0d, required 3/1/0",
               xfer_cnt - x0, done_cnt - d0, sb.size());
    end
  endtask

  task automatic test_reset_abort();
    int cyc, bad, d0;
    // Reset while a pair is presented: valid must drop before the next edge.
    coef_ready = 1'b0;
    do_start(4'd0, 5'd4, 1'b1);
    wait_valid(cyc);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (coef_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_async_valid: got valid=%b busy=%b, required 0/0", coef_valid, busy);
    end
    sb.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Reset in WAIT of word 2 of 4.
    coef_ready = 1'b1;
    do_start(4'd0, 5'd4, 1'b1);
    repeat (5) step();
    n_vec++;
    if (busy !== 1'b1 || coef_valid !== 1'b0) begin
      n_err++;
      $display("FAIL abort_pre_wait: got busy=%b valid=%b, required 1/0", busy, coef_valid);
    end
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({rom_ad, rom_ce, rom_oce, coef_ftw, coef_phase, coef_valid, busy, done} !== '0) begin
      n_err++;
      $display("FAIL abort_outputs: got ad=%0h ce=%b v=%b busy=%b done=%b, required all 0",
               rom_ad, rom_ce, coef_valid, busy, done);
    end
    sb.delete();
    repeat (3) step();
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      step();
      if (busy || coef_valid) bad++;
    end
    n_vec++;
    if (bad !== 0 || done_cnt !== d0) begin
      n_err++;
      $display("FAIL abort_idle: got %0d active clocks, %0d dones, required 0/0", bad, done_cnt - d0);
    end
    do_start(4'd5, 5'd1, 1'b1);
    wait_valid(cyc);
    n_vec++;
    if (cyc !== 3 || coef_ftw !== 32'h1000_0005) begin
      n_err++;
      $display("FAIL abort_restart: got %0d clocks ftw=%h, required 3 clocks ftw=10000005", cyc, coef_ftw);
    end
    wait_idle();
    n_vec++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL abort_pending: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_ignored();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
